// File: rtl/mcs4_pc_stack.sv
// MCS-4 program-counter stack (circular, JMS/BBL style) with sticky level flags and an LSB-first address nibble serialiser.
// PC/level/flags update one edge after an op; nibbles stream the cycles after a start, with no backpressure.
module mcs4_pc_stack #(
  parameter int ADDR_W = 12,
  parameter int NIB_W  = 4,
  parameter int DEPTH  = 4,
  parameter int PAGE_W = 8
) (
  input  logic                     clk_i,
  input  logic                     RESET_i,
  input  logic                     op_valid_i,
  input  logic [2:0]               op_i,
  input  logic [ADDR_W-1:0]        target_i,
  input  logic                     clr_flags_i,
  input  logic                     addr_start_i,
  output logic [ADDR_W-1:0]        pc_o,
  output logic [$clog2(DEPTH)-1:0] level_o,
  output logic                     overflow_o,
  output logic                     underflow_o,
  output logic [NIB_W-1:0]         addr_nib_o,
  output logic                     addr_valid_o,
  output logic                     addr_last_o
);
  localparam int SP_W    = $clog2(DEPTH);
  localparam int NIBBLES = ADDR_W / NIB_W;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [SP_W-1:0]  LVL_MAX  = SP_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

  localparam logic [2:0] OP_INC  = 3'd1;
  localparam logic [2:0] OP_JUMP = 3'd2;
  localparam logic [2:0] OP_PAGE = 3'd3;
  localparam logic [2:0] OP_CALL = 3'd4;
  localparam logic [2:0] OP_RET  = 3'd5;

  typedef enum logic {S_IDLE, S_SHIFT} state_e;

  logic [ADDR_W-1:0] stack_q [DEPTH];
  logic [ADDR_W-1:0] stack_d [DEPTH];
  logic [SP_W-1:0]   sp_q, sp_d, sp_inc, sp_dec;
  logic [SP_W-1:0]   level_q, level_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic [ADDR_W-1:0] pc_cur, pc_inc;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] snap_q, snap_d;
  logic              valid_q, valid_d, last_q, last_d;

  assign pc_cur = stack_q[sp_q];
  assign pc_inc = pc_cur + 1'b1;
  assign sp_inc = sp_q + 1'b1;
  assign sp_dec = sp_q - 1'b1;

  // Clear is applied first so a same-edge CALL/RET flag set wins.
  always_comb begin
    stack_d = stack_q;
    sp_d    = sp_q;
    level_d = level_q;
    ovf_d   = ovf_q & ~clr_flags_i;
    unf_d   = unf_q & ~clr_flags_i;
    if (op_valid_i) begin
      case (op_i)
        OP_INC:  stack_d[sp_q] = pc_inc;
        OP_JUMP: stack_d[sp_q] = target_i;
        OP_PAGE: stack_d[sp_q][PAGE_W-1:0] = target_i[PAGE_W-1:0];
        OP_CALL: begin
          stack_d[sp_q]   = pc_inc;
          stack_d[sp_inc] = target_i;
          sp_d            = sp_inc;
          if (level_q != LVL_MAX) level_d = level_q + 1'b1;
          else                    ovf_d   = 1'b1;
        end
        OP_RET: begin
          sp_d = sp_dec;
          if (level_q != '0) level_d = level_q - 1'b1;
          else               unf_d   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Snapshot is a shift register so the output nibble is always its low bits.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    valid_d = valid_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (addr_start_i) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          snap_d  = pc_cur;
          valid_d = 1'b1;
          last_d  = (CNT_LAST == '0);
        end
      end
      S_SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          snap_d  = '0;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          snap_d  = snap_q >> NIB_W;
          valid_d = 1'b1;
          last_d  = (cnt_d == CNT_LAST);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge RESET_i) begin
    if (RESET_i) begin
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
      sp_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      snap_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      stack_q <= stack_d;
      sp_q    <= sp_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign pc_o         = pc_cur;
  assign level_o      = level_q;
  assign overflow_o   = ovf_q;
  assign underflow_o  = unf_q;
  assign addr_nib_o   = snap_q[NIB_W-1:0];
  assign addr_valid_o = valid_q;
  assign addr_last_o  = last_q;

endmodule
